pipe_hazard_controller: RTL

//  Next-gen control unit for the 5-stage MIPS pipeline. Main/ALU decode in D.

---
 rtl/pipe_hazard_controller.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_controller.sv
// pipe_hazard_controller: D-stage main/ALU decode, D->E->M->W control pipe, hazard/forward unit, mult/div sequencer.
// Latency: decode, hazard and forward outputs are combinational; stage controls advance one register per stage.
// Backpressure: load-use/branch hazards hold F/D and bubble E; a mult/div holds E for MD_LATENCY cycles and bubbles M.
module pipe_hazard_controller #(
  parameter int ALUCTRL_W  = 6,
  parameter int RA_W       = 5,
  parameter int MD_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opD,
  input  logic [5:0]           functD,
  input  logic                 equalD,
  input  logic [RA_W-1:0]      rsD,
  input  logic [RA_W-1:0]      rtD,
  input  logic [RA_W-1:0]      rsE,
  input  logic [RA_W-1:0]      rtE,
  input  logic [RA_W-1:0]      writeregE,
  input  logic [RA_W-1:0]      writeregM,
  input  logic [RA_W-1:0]      writeregW,
  output logic                 pcsrcD,
  output logic                 jumpD,
  output logic                 zeroextendD,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 forwardAD,
  output logic                 forwardBD,
  output logic [1:0]           forwardAE,
  output logic [1:0]           forwardBE,
  output logic                 alusrcE,
  output logic                 regdstE,
  output logic                 regwriteE,
  output logic                 memtoregE,
  output logic [ALUCTRL_W-1:0] alucontrolE,
  output logic                 memwriteM,
  output logic                 regwriteM,
  output logic                 memtoregM,
  output logic                 regwriteW,
  output logic                 memtoregW,
  output logic                 md_startE,
  output logic                 md_busy
);

  // Opcodes and function codes understood by the decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  // ALU control reuses the R-type funct encoding: add / sub / or
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_OR    = 6'h25;

  localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  // Control bundle carried into E
  typedef struct packed {
    logic                 regwrite;
    logic                 memtoreg;
    logic                 memwrite;
    logic                 alusrc;
    logic                 regdst;
    logic                 md;
    logic [ALUCTRL_W-1:0] alucontrol;
  } ectl_t;

  // Control bundle carried into M
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } mctl_t;

  // Control bundle carried into W
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wctl_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  ectl_t            ctlD;
  logic             branchD;
  ectl_t            e_q, e_d;
  mctl_t            m_q, m_d;
  wctl_t            w_q, w_d;
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             lwstall, brstall, mdstall, stallE;
  logic             wrE_nz, wrM_nz, wrW_nz;
  logic             hitE_D, hitM_D;

  // Main + ALU decode of the D-stage instruction; unknown opcodes decode to all-zero controls
  always_comb begin
    ctlD        = '0;
    branchD     = 1'b0;
    jumpD       = 1'b0;
    zeroextendD = 1'b0;
    unique case (opD)
      OP_RTYPE: begin
        ctlD.regwrite   = 1'b1;
        ctlD.regdst     = 1'b1;
        ctlD.alucontrol = ALUCTRL_W'(functD);
        // mult/div write HI/LO inside the MD unit, never the register file
        if (functD == FN_MULT || functD == FN_DIV) begin
          ctlD.md       = 1'b1;
          ctlD.regwrite = 1'b0;
        end
      end
      OP_LW: begin
        ctlD.regwrite   = 1'b1;
        ctlD.memtoreg   = 1'b1;
        ctlD.alusrc     = 1'b1;
        ctlD.alucontrol = ALUCTRL_W'(FN_ADD);
      end
      OP_SW: begin
        ctlD.memwrite   = 1'b1;
        ctlD.alusrc     = 1'b1;
        ctlD.alucontrol = ALUCTRL_W'(FN_ADD);
      end
      OP_BEQ: begin
        branchD         = 1'b1;
        ctlD.alucontrol = ALUCTRL_W'(FN_SUB);
      end
      OP_ADDI: begin
        ctlD.regwrite   = 1'b1;
        ctlD.alusrc     = 1'b1;
        ctlD.alucontrol = ALUCTRL_W'(FN_ADD);
      end
      OP_ORI: begin
        ctlD.regwrite   = 1'b1;
        ctlD.alusrc     = 1'b1;
        zeroextendD     = 1'b1;
        ctlD.alucontrol = ALUCTRL_W'(FN_OR);
      end
      OP_J: begin
        jumpD = 1'b1;
      end
      default: begin
        ctlD = '0;
      end
    endcase
  end

  assign pcsrcD = branchD & equalD;

  // Register 0 is hard-wired, so a producer targeting it is never a dependency
  assign wrE_nz = |writeregE;
  assign wrM_nz = |writeregM;
  assign wrW_nz = |writeregW;
  assign hitE_D = wrE_nz & ((writeregE == rsD) | (writeregE == rtD));
  assign hitM_D = wrM_nz & ((writeregM == rsD) | (writeregM == rtD));

  assign lwstall = e_q.memtoreg & hitE_D;
  assign brstall = branchD & ((e_q.regwrite & hitE_D) | (m_q.memtoreg & hitM_D));
  assign stallE  = mdstall;
  assign stallF  = lwstall | brstall | mdstall;
  assign stallD  = stallF;
  // A held E stage keeps its mult/div, so it must not also be flushed
  assign flushE  = (lwstall | brstall) & ~mdstall;
  // No delay slot: the wrong-path fetch is squashed unless D itself is held
  assign flushD  = (pcsrcD | jumpD) & ~stallD;

  // Forwarding selects: E operands prefer the younger M result, D compare only from M
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (m_q.regwrite && wrM_nz && writeregM == rsE)      forwardAE = 2'b10;
    else if (w_q.regwrite && wrW_nz && writeregW == rsE) forwardAE = 2'b01;
    if (m_q.regwrite && wrM_nz && writeregM == rtE)      forwardBE = 2'b10;
    else if (w_q.regwrite && wrW_nz && writeregW == rtE) forwardBE = 2'b01;
    forwardAD = m_q.regwrite & wrM_nz & (writeregM == rsD);
    forwardBD = m_q.regwrite & wrM_nz & (writeregM == rtD);
  end

  // Next-state of the control pipe: E hold beats flush, M takes a bubble while E is held
  always_comb begin
    e_d = ctlD;
    if (stallE)      e_d = e_q;
    else if (flushE) e_d = '0;
    m_d = stallE ? '0 : '{regwrite: e_q.regwrite, memtoreg: e_q.memtoreg, memwrite: e_q.memwrite};
    w_d = '{regwrite: m_q.regwrite, memtoreg: m_q.memtoreg};
  end

  // Control pipe registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Mult/div sequencer state register; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next state: IDLE launches, BUSY counts down, DONE releases E for one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (e_q.md) begin
          if (MD_LATENCY == 1) begin
            state_d = MD_DONE;
          end else begin
            state_d = MD_BUSY;
            cnt_d   = CNT_W'(MD_LATENCY - 1);
          end
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = MD_DONE;
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer outputs: launch pulse, busy flag and the E-stage hold request
  always_comb begin
    md_startE = (state_q == MD_IDLE) & e_q.md;
    md_busy   = (state_q != MD_IDLE);
    mdstall   = e_q.md & (state_q != MD_DONE);
  end

  assign alusrcE     = e_q.alusrc;
  assign regdstE     = e_q.regdst;
  assign regwriteE   = e_q.regwrite;
  assign memtoregE   = e_q.memtoreg;
  assign alucontrolE = e_q.alucontrol;
  assign memwriteM   = m_q.memwrite;
  assign regwriteM   = m_q.regwrite;
  assign memtoregM   = m_q.memtoreg;
  assign regwriteW   = w_q.regwrite;
  assign memtoregW   = w_q.memtoreg;

endmodule
